// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer feeding one
// registered output slot. Arbitration is round-robin, fixed priority
// (lowest index wins), or manual select via sel, chosen by MODE.
// The output register reloads whenever it is empty or being drained,
// so a continuously ready consumer sees one word per cycle.
module stream_mux_rr #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*W-1:0]     in_data,
    output logic [NCH-1:0]       in_ready,
    input  logic [CW-1:0]        sel,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    // Output slot and round-robin pointer
    logic            vld_p1;
    logic [W-1:0]    out_data_p1;
    logic [CW-1:0]   out_ch_p1;
    logic [CW-1:0]   last_p1;

    // Grant decision for the current cycle
    logic            load;
    logic            gnt_any;
    logic [CW-1:0]   gnt_idx;
    logic [W-1:0]    gnt_data;
    logic [CW:0]     pick;

    // Round-robin search: starts one past the pointer and wraps at NCH,
    // not at 2^CW, so non-power-of-two channel counts stay fair.
    function automatic logic [CW:0] pick_rr(input logic [NCH-1:0] req,
                                            input logic [CW-1:0]  ptr);
        logic [CW-1:0] idx;
        logic [CW-1:0] hit;
        logic          found;
        idx   = ptr;
        hit   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (idx == CW'(NCH - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found = 1'b1;
                hit   = idx;
            end
        end
        return {found, hit};
    endfunction

    // Fixed priority: scan from the top down so the lowest index is kept.
    function automatic logic [CW:0] pick_fixed(input logic [NCH-1:0] req);
        logic [CW-1:0] hit;
        logic          found;
        hit   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                hit   = CW'(i);
            end
        end
        return {found, hit};
    endfunction

    // Manual select: a select value with no matching channel never grants.
    function automatic logic [CW:0] pick_sel(input logic [NCH-1:0] req,
                                             input logic [CW-1:0]  s);
        logic [CW-1:0] hit;
        logic          found;
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (s == CW'(i) && req[i]) begin
                found = 1'b1;
                hit   = CW'(i);
            end
        end
        return {found, hit};
    endfunction

    // Load enable and arbitration; ready is held low throughout reset.
    always_comb begin
        load = rst_n && (!vld_p1 || out_ready);
        pick = '0;
        case (MODE)
            0:       pick = pick_rr(in_valid, last_p1);
            1:       pick = pick_fixed(in_valid);
            2:       pick = pick_sel(in_valid, sel);
            default: pick = '0;
        endcase
        gnt_any = load && pick[CW];
        gnt_idx = pick[CW-1:0];
    end

    // One-hot ready for the granted channel and the matching data word.
    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = gnt_any && (gnt_idx == CW'(i));
            if (gnt_idx == CW'(i)) begin
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    // Output register: reload on accept/empty, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_ch_p1   <= '0;
            last_p1     <= CW'(NCH - 1);
        end else if (load) begin
            vld_p1 <= gnt_any;
            if (gnt_any) begin
                out_data_p1 <= gnt_data;
                out_ch_p1   <= gnt_idx;
                if (MODE == 0) begin
                    last_p1 <= gnt_idx;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;
    assign out_ch    = out_ch_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: round-robin, fixed priority and manual
// select instances share one stimulus set; each phase checks one instance.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0] r0_in_ready, r1_in_ready, r2_in_ready;
    logic [2:0] r3_in_ready;
    logic       r0_out_valid, r1_out_valid, r2_out_valid, r3_out_valid;
    logic [7:0] r0_out_data, r1_out_data, r2_out_data, r3_out_data;
    logic [1:0] r0_out_ch, r1_out_ch, r2_out_ch, r3_out_ch;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.NCH(4), .W(8), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r0_in_ready), .sel(sel), .out_valid(r0_out_valid),
        .out_data(r0_out_data), .out_ch(r0_out_ch), .out_ready(out_ready));

    stream_mux_rr #(.NCH(4), .W(8), .MODE(1)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r1_in_ready), .sel(sel), .out_valid(r1_out_valid),
        .out_data(r1_out_data), .out_ch(r1_out_ch), .out_ready(out_ready));

    stream_mux_rr #(.NCH(4), .W(8), .MODE(2)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r2_in_ready), .sel(sel), .out_valid(r2_out_valid),
        .out_data(r2_out_data), .out_ch(r2_out_ch), .out_ready(out_ready));

    stream_mux_rr #(.NCH(3), .W(8), .MODE(2)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_data(in_data[23:0]),
        .in_ready(r3_in_ready), .sel(sel), .out_valid(r3_out_valid),
        .out_data(r3_out_data), .out_ch(r3_out_ch), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h44332211;
        sel       = 2'd0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(r0_out_valid), 0);
        chk("rst_data",  32'(r0_out_data), 0);
        chk("rst_ch",    32'(r0_out_ch), 0);
        chk("rst_ready", 32'(r0_in_ready), 0);

        // Requests present during reset must not see ready.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_ready_gated", 32'(r0_in_ready), 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(r0_in_ready), 32'b0001);

        // Fairness: 0,1,2,3,0,1
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_valid", 32'(r0_out_valid), 1);
            chk("rr_ch",    32'(r0_out_ch), 32'(k % 4));
            chk("rr_data",  32'(r0_out_data), 32'((k % 4 + 1) * 8'h11));
        end

        // Backpressure with ch1 / 8'h22 held
        out_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(r0_in_ready), 0);
        repeat (3) begin
            tick();
            chk("bp_valid", 32'(r0_out_valid), 1);
            chk("bp_data",  32'(r0_out_data), 32'h22);
            chk("bp_ch",    32'(r0_out_ch), 1);
            chk("bp_ready_hold", 32'(r0_in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(r0_in_ready), 32'b0100);
        tick();
        chk("bp_next_ch",   32'(r0_out_ch), 2);
        chk("bp_next_data", 32'(r0_out_data), 32'h33);
        tick();
        chk("rr_ch3", 32'(r0_out_ch), 3);

        // Single requester at the wrap point
        in_valid = 4'b1000;
        #1;
        chk("single_ready", 32'(r0_in_ready), 32'b1000);
        repeat (2) begin
            tick();
            chk("single_ch",    32'(r0_out_ch), 3);
            chk("single_valid", 32'(r0_out_valid), 1);
        end

        // Sparse pair alternates
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sparse_ch", 32'(r0_out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Drain with no grant: valid drops, data/channel hold, pointer frozen
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(r0_out_valid), 0);
        chk("drain_data",  32'(r0_out_data), 32'h44);
        chk("drain_ch",    32'(r0_out_ch), 3);
        in_valid = 4'b1111;
        #1;
        chk("idle_ptr_ready", 32'(r0_in_ready), 32'b0001);
        tick();
        chk("idle_ptr_ch", 32'(r0_out_ch), 0);
        tick();
        chk("pre_rst_data", 32'(r0_out_data), 32'h22);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(r0_out_valid), 0);
        chk("arst_data",  32'(r0_out_data), 0);
        chk("arst_ch",    32'(r0_out_ch), 0);
        chk("arst_ready", 32'(r0_in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_first_ready", 32'(r0_in_ready), 32'b0001);
        tick();
        chk("arst_first_ch", 32'(r0_out_ch), 0);
        chk("arst_first_data", 32'(r0_out_data), 32'h11);

        // Fixed priority
        in_valid = 4'b1010;
        #1;
        chk("fix_ready", 32'(r1_in_ready), 32'b0010);
        repeat (3) begin
            tick();
            chk("fix_ch",    32'(r1_out_ch), 1);
            chk("fix_data",  32'(r1_out_data), 32'h22);
            chk("fix_ready_cyc", 32'(r1_in_ready), 32'b0010);
        end

        // Manual select
        sel      = 2'd2;
        in_valid = 4'b0100;
        #1;
        chk("sel_ready", 32'(r2_in_ready), 32'b0100);
        tick();
        chk("sel_ch",    32'(r2_out_ch), 2);
        chk("sel_data",  32'(r2_out_data), 32'h33);
        chk("sel_valid", 32'(r2_out_valid), 1);
        in_valid = 4'b0001;
        #1;
        chk("sel_nogrant_ready", 32'(r2_in_ready), 0);
        tick();
        chk("sel_drop_valid", 32'(r2_out_valid), 0);
        chk("sel_hold_data",  32'(r2_out_data), 32'h33);

        sel      = 2'd3;
        in_valid = 4'b1111;
        #1;
        chk("sel3_nch3_ready", 32'(r3_in_ready), 0);
        chk("sel3_nch4_ready", 32'(r2_in_ready), 32'b1000);
        tick();
        chk("sel3_nch3_valid", 32'(r3_out_valid), 0);
        chk("sel3_nch3_data",  32'(r3_out_data), 32'h33);
        chk("sel3_nch4_ch",    32'(r2_out_ch), 3);
        chk("sel3_nch4_data",  32'(r2_out_data), 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
